// File: rtl/minimig_sram_responder.sv
// minimig_sram_responder: turns sampled async-SRAM strobes into req/ack
// memory requests (one or two per access) and returns read data.
// Ports: clk, reset (sync, active high); SRAM side _we/_oe/_bhe/_ble/
//   _bhe2/_ble2, address, data, data2 -> ramdata_out; status busy,
//   timeout_err; memory side mem_req/mem_we/mem_addr/mem_ben/mem_wdata
//   out, mem_ack/mem_rdata in.
// Option: define SRAM_RESP_RDCACHE_EN for a one-entry read cache.
module minimig_sram_responder #(
  parameter int ADDR_W  = 22,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            _we,
  input  logic            _oe,
  input  logic            _bhe,
  input  logic            _ble,
  input  logic            _bhe2,
  input  logic            _ble2,
  input  logic [ADDR_W:1] address,
  input  logic [15:0]     data,
  input  logic [15:0]     data2,
  output logic [15:0]     ramdata_out,
  output logic            busy,
  output logic            timeout_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [ADDR_W:1] mem_addr,
  output logic [1:0]      mem_ben,
  output logic [15:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata
);

  localparam int SIG_W = ADDR_W + 6;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W:1] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_W0,
    S_W1,
    S_DONE
  } state_t;

  logic            r_we;
  logic            r_oe;
  logic            r_bhe;
  logic            r_ble;
  logic            r_bhe2;
  logic            r_ble2;
  logic [ADDR_W:1] r_addr;
  logic [15:0]     r_data;
  logic [15:0]     r_data2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b1;
      r_oe    <= 1'b1;
      r_bhe   <= 1'b1;
      r_ble   <= 1'b1;
      r_bhe2  <= 1'b1;
      r_ble2  <= 1'b1;
      r_addr  <= '0;
      r_data  <= '0;
      r_data2 <= '0;
    end else begin
      r_we    <= _we;
      r_oe    <= _oe;
      r_bhe   <= _bhe;
      r_ble   <= _ble;
      r_bhe2  <= _bhe2;
      r_ble2  <= _ble2;
      r_addr  <= address;
      r_data  <= data;
      r_data2 <= data2;
    end
  end

  state_t          r_state;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [ADDR_W:1] r_mem_addr;
  logic [1:0]      r_mem_ben;
  logic [15:0]     r_mem_wdata;
  logic [15:0]     r_rdata;
  logic            r_err;
  logic [7:0]      r_tcnt;
  logic [SIG_W-1:0] r_l_sig;
  logic [ADDR_W:1] r_l_addr;
  logic [1:0]      r_l_ben0;
  logic [1:0]      r_l_ben1;
  logic [15:0]     r_l_d0;
  logic [15:0]     r_l_d1;

  state_t          w_state_n;
  logic            w_req_n;
  logic            w_we_n;
  logic [ADDR_W:1] w_addr_n;
  logic [1:0]      w_ben_n;
  logic [15:0]     w_wdata_n;
  logic [15:0]     w_rdata_n;
  logic            w_err_n;
  logic [7:0]      w_tcnt_n;
  logic [SIG_W-1:0] w_l_sig_n;
  logic [ADDR_W:1] w_l_addr_n;
  logic [1:0]      w_l_ben0_n;
  logic [1:0]      w_l_ben1_n;
  logic [15:0]     w_l_d0_n;
  logic [15:0]     w_l_d1_n;

`ifdef SRAM_RESP_RDCACHE_EN
  logic            r_c_valid;
  logic [ADDR_W:1] r_c_addr;
  logic [15:0]     r_c_data;
  logic            w_c_valid_n;
  logic [ADDR_W:1] w_c_addr_n;
  logic [15:0]     w_c_data_n;
`endif

  logic [SIG_W-1:0] w_sig;
  logic            w_active;
  logic            w_tmo;
  logic [ADDR_W:1] w_in_addr1;
  logic [ADDR_W:1] w_l_addr1;

  assign w_sig = {r_addr, r_we, r_oe, r_bhe, r_ble, r_bhe2, r_ble2};
  assign w_active = ~r_we | ~r_oe;
  assign w_tmo = (r_tcnt == TMO_LAST);
  assign w_in_addr1 = r_addr + ONE;
  assign w_l_addr1 = r_l_addr + ONE;

  always_comb begin
    w_state_n  = r_state;
    w_req_n    = r_mem_req;
    w_we_n     = r_mem_we;
    w_addr_n   = r_mem_addr;
    w_ben_n    = r_mem_ben;
    w_wdata_n  = r_mem_wdata;
    w_rdata_n  = r_rdata;
    w_err_n    = r_err;
    w_tcnt_n   = r_mem_req ? r_tcnt + 8'd1 : 8'd0;
    w_l_sig_n  = r_l_sig;
    w_l_addr_n = r_l_addr;
    w_l_ben0_n = r_l_ben0;
    w_l_ben1_n = r_l_ben1;
    w_l_d0_n   = r_l_d0;
    w_l_d1_n   = r_l_d1;
`ifdef SRAM_RESP_RDCACHE_EN
    w_c_valid_n = r_c_valid;
    w_c_addr_n  = r_c_addr;
    w_c_data_n  = r_c_data;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_active) begin
          w_l_sig_n  = w_sig;
          w_l_addr_n = r_addr;
          w_l_ben0_n = {~r_bhe, ~r_ble};
          w_l_ben1_n = {~r_bhe2, ~r_ble2};
          w_l_d0_n   = r_data;
          w_l_d1_n   = r_data2;
          if (!r_we) begin
            w_state_n = S_W0;
`ifdef SRAM_RESP_RDCACHE_EN
            if (r_c_addr == r_addr || r_c_addr == w_in_addr1)
              w_c_valid_n = 1'b0;
`endif
          end else begin
`ifdef SRAM_RESP_RDCACHE_EN
            if (r_c_valid && r_c_addr == r_addr) begin
              w_rdata_n = r_c_data;
              w_state_n = S_DONE;
            end else begin
              w_state_n = S_RD;
              w_req_n   = 1'b1;
              w_we_n    = 1'b0;
              w_addr_n  = r_addr;
              w_ben_n   = 2'b11;
            end
`else
            w_state_n = S_RD;
            w_req_n   = 1'b1;
            w_we_n    = 1'b0;
            w_addr_n  = r_addr;
            w_ben_n   = 2'b11;
`endif
          end
        end
      end
      S_RD: begin
        if (mem_ack) begin
          w_req_n   = 1'b0;
          w_rdata_n = mem_rdata;
          w_state_n = S_DONE;
`ifdef SRAM_RESP_RDCACHE_EN
          w_c_valid_n = 1'b1;
          w_c_addr_n  = r_mem_addr;
          w_c_data_n  = mem_rdata;
`endif
        end else if (w_tmo) begin
          w_req_n   = 1'b0;
          w_err_n   = 1'b1;
          w_state_n = S_DONE;
`ifdef SRAM_RESP_RDCACHE_EN
          w_c_valid_n = 1'b0;
`endif
        end
      end
      S_W0, S_W1: begin
        // W0/W1 enter with mem_req low; a request is only raised when
        // that word has at least one byte enabled.
        if (!r_mem_req) begin
          if ((r_state == S_W0 ? r_l_ben0 : r_l_ben1) == 2'b00) begin
            w_state_n = (r_state == S_W0) ? S_W1 : S_DONE;
          end else begin
            w_req_n   = 1'b1;
            w_we_n    = 1'b1;
            w_addr_n  = (r_state == S_W0) ? r_l_addr : w_l_addr1;
            w_ben_n   = (r_state == S_W0) ? r_l_ben0 : r_l_ben1;
            w_wdata_n = (r_state == S_W0) ? r_l_d0 : r_l_d1;
          end
        end else if (mem_ack) begin
          w_req_n   = 1'b0;
          w_state_n = (r_state == S_W0) ? S_W1 : S_DONE;
        end else if (w_tmo) begin
          w_req_n   = 1'b0;
          w_err_n   = 1'b1;
          w_state_n = S_DONE;
`ifdef SRAM_RESP_RDCACHE_EN
          w_c_valid_n = 1'b0;
`endif
        end
      end
      S_DONE: begin
        // One service per distinct access: wait for the bus to move on.
        if (!w_active || w_sig != r_l_sig)
          w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_ben   <= 2'b00;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_tcnt      <= '0;
      r_l_sig     <= '0;
      r_l_addr    <= '0;
      r_l_ben0    <= 2'b00;
      r_l_ben1    <= 2'b00;
      r_l_d0      <= '0;
      r_l_d1      <= '0;
`ifdef SRAM_RESP_RDCACHE_EN
      r_c_valid   <= 1'b0;
      r_c_addr    <= '0;
      r_c_data    <= '0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_mem_req   <= w_req_n;
      r_mem_we    <= w_we_n;
      r_mem_addr  <= w_addr_n;
      r_mem_ben   <= w_ben_n;
      r_mem_wdata <= w_wdata_n;
      r_rdata     <= w_rdata_n;
      r_err       <= w_err_n;
      r_tcnt      <= w_tcnt_n;
      r_l_sig     <= w_l_sig_n;
      r_l_addr    <= w_l_addr_n;
      r_l_ben0    <= w_l_ben0_n;
      r_l_ben1    <= w_l_ben1_n;
      r_l_d0      <= w_l_d0_n;
      r_l_d1      <= w_l_d1_n;
`ifdef SRAM_RESP_RDCACHE_EN
      r_c_valid   <= w_c_valid_n;
      r_c_addr    <= w_c_addr_n;
      r_c_data    <= w_c_data_n;
`endif
    end
  end

  assign ramdata_out = r_rdata;
  assign busy        = r_mem_req;
  assign timeout_err = r_err;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_ben     = r_mem_ben;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_minimig_sram_responder.sv
// tb_minimig_sram_responder: randomized accesses against a word-level
// memory model; a TB memory responds on the req/ack port.
module tb_minimig_sram_responder;

  typedef struct {
    logic [21:0] a;
    logic        we;
    logic [1:0]  ben;
    logic [15:0] wd;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we_n = 1'b1;
  logic        oe_n = 1'b1;
  logic        bhe_n = 1'b1;
  logic        ble_n = 1'b1;
  logic        bhe2_n = 1'b1;
  logic        ble2_n = 1'b1;
  logic [22:1] addr = '0;
  logic [15:0] d0 = '0;
  logic [15:0] d1 = '0;
  logic [15:0] ramdata_out;
  logic        busy;
  logic        timeout_err;
  logic        mem_req;
  logic        mem_we;
  logic [22:1] mem_addr;
  logic [1:0]  mem_ben;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  minimig_sram_responder dut (
    .clk(clk),
    .reset(reset),
    ._we(we_n),
    ._oe(oe_n),
    ._bhe(bhe_n),
    ._ble(ble_n),
    ._bhe2(bhe2_n),
    ._ble2(ble2_n),
    .address(addr),
    .data(d0),
    .data2(d1),
    .ramdata_out(ramdata_out),
    .busy(busy),
    .timeout_err(timeout_err),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_ben(mem_ben),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic [1:0] ben,
                                        input logic [15:0] wd);
    return {ben[1] ? wd[15:8] : old[15:8], ben[0] ? wd[7:0] : old[7:0]};
  endfunction

  logic [15:0] mem_dut [bit [21:0]];
  logic [15:0] mem_ref [bit [21:0]];

  function automatic logic [15:0] dut_rd(input logic [21:0] a);
    return mem_dut.exists(a) ? mem_dut[a] : (a[15:0] ^ 16'h5A3C);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [21:0] a);
    return mem_ref.exists(a) ? mem_ref[a] : (a[15:0] ^ 16'h5A3C);
  endfunction

  // memory responder
  req_t obs_q[$];
  req_t cur;
  bit   in_req = 0;
  bit   mute = 0;
  int   dly = 0;
  int   fixed_dly = -1;
  int   hi_cnt = 0;
  int   unstable = 0;

  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req) begin
        in_req = 0;
      end else begin
        if (!in_req) begin
          in_req = 1;
          cur = '{mem_addr, mem_we, mem_ben, mem_wdata};
          obs_q.push_back(cur);
          hi_cnt = 0;
          dly = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, 4);
        end else if (mem_addr !== cur.a || mem_we !== cur.we ||
                     mem_ben !== cur.ben || mem_wdata !== cur.wd) begin
          unstable++;
        end
        hi_cnt++;
        if (!mute) begin
          if (dly == 0) begin
            if (cur.we)
              mem_dut[cur.a] = merge(dut_rd(cur.a), cur.ben, cur.wd);
            else
              mem_rdata = dut_rd(cur.a);
            mem_ack = 1'b1;
            in_req = 0;
          end else begin
            dly--;
          end
        end
      end
    end
  end

  // reference model state
  req_t        exp_q[$];
  logic [15:0] exp_rd = '0;
  bit          c_valid = 0;
  logic [21:0] c_addr = '0;

  task automatic do_access(input string tag, input logic [21:0] a,
                           input bit wr, input logic oe_w,
                           input logic [3:0] be, input logic [15:0] w0,
                           input logic [15:0] w1, input int hold);
    req_t e;
    logic [21:0] a1;
    bit hit;
    a1 = a + 22'd1;
    hit = 0;
    exp_q.delete();
    if (wr) begin
      if (be[3:2] != 2'b11) begin
        e = '{a, 1'b1, ~be[3:2], w0};
        exp_q.push_back(e);
        mem_ref[a] = merge(ref_rd(a), e.ben, w0);
      end
      if (be[1:0] != 2'b11) begin
        e = '{a1, 1'b1, ~be[1:0], w1};
        exp_q.push_back(e);
        mem_ref[a1] = merge(ref_rd(a1), e.ben, w1);
      end
      if (c_addr == a || c_addr == a1) c_valid = 0;
    end else begin
`ifdef SRAM_RESP_RDCACHE_EN
      hit = c_valid && c_addr == a;
`endif
      if (!hit) begin
        e = '{a, 1'b0, 2'b11, 16'h0};
        exp_q.push_back(e);
        c_valid = 1;
        c_addr = a;
      end
      exp_rd = ref_rd(a);
    end
    @(negedge clk);
    obs_q.delete();
    unstable = 0;
    we_n = !wr;
    oe_n = wr ? oe_w : 1'b0;
    {bhe_n, ble_n, bhe2_n, ble2_n} = be;
    addr = a;
    d0 = w0;
    d1 = w1;
    repeat (hold) @(negedge clk);
    chk({tag, "_nreq"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_addr"}, obs_q[i].a, exp_q[i].a);
      chk({tag, "_we"}, obs_q[i].we, exp_q[i].we);
      chk({tag, "_ben"}, obs_q[i].ben, exp_q[i].ben);
      if (exp_q[i].we) chk({tag, "_wdata"}, obs_q[i].wd, exp_q[i].wd);
    end
    if (!wr) chk({tag, "_rdata"}, ramdata_out, exp_rd);
    chk({tag, "_stable"}, unstable, 0);
    chk({tag, "_busy"}, busy, 0);
    we_n = 1'b1;
    oe_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  logic [21:0] pool [6];

  initial begin
    pool[0] = 22'h000100;
    pool[1] = 22'h000101;
    pool[2] = 22'h0000FF;
    pool[3] = 22'h3FFFFF;
    pool[4] = 22'h000000;
    pool[5] = 22'h012345;

    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", ramdata_out, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ben", mem_ben, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    mem_dut[22'h012345] = 16'hBEEF;
    mem_ref[22'h012345] = 16'hBEEF;
    fixed_dly = 3;
    do_access("rd1", 22'h012345, 0, 1'b1, 4'hF, 16'h0, 16'h0, 32);
    fixed_dly = -1;

    do_access("lw", 22'h3FFFFF, 1, 1'b1, 4'b0001, 16'h1111, 16'h2222, 30);
    do_access("w2only", 22'h000200, 1, 1'b1, 4'b1101, 16'h3333,
              16'h4444, 30);
    do_access("rdw2", 22'h000201, 0, 1'b1, 4'hF, 16'h0, 16'h0, 30);

    for (int n = 0; n < 60; n++) begin
      do_access("rnd", pool[$urandom_range(0, 5)], bit'($urandom % 2),
                1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
                30);
    end

    // timeout on a muted read
    @(negedge clk);
    obs_q.delete();
    mute = 1;
    we_n = 1'b1;
    addr = 22'h2AAAAA;
    oe_n = 1'b0;
    repeat (300) @(negedge clk);
    chk("to_nreq", obs_q.size(), 1);
    chk("to_hicnt", hi_cnt, 255);
    chk("to_err", timeout_err, 1);
    chk("to_rdata", ramdata_out, exp_rd);
    chk("to_req", mem_req, 0);
    oe_n = 1'b1;
    mute = 0;
    c_valid = 0;
    repeat (3) @(negedge clk);
    do_access("to_next", 22'h2AAAAA, 0, 1'b1, 4'hF, 16'h0, 16'h0, 30);
    chk("to_sticky", timeout_err, 1);

    do_access("c_rd1", 22'h000100, 0, 1'b1, 4'h0, 16'h0, 16'h0, 30);
    do_access("c_rd2", 22'h000100, 0, 1'b1, 4'h0, 16'h0, 16'h0, 30);
    do_access("c_wr", 22'h000100, 1, 1'b1, 4'b0011, 16'h7E57,
              16'h0, 30);
    do_access("c_rd3", 22'h000100, 0, 1'b1, 4'h0, 16'h0, 16'h0, 30);

    // reset while a read is outstanding
    @(negedge clk);
    obs_q.delete();
    mute = 1;
    addr = 22'h155555;
    oe_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("rr_pre_req", mem_req, 1);
    reset = 1'b1;
    oe_n = 1'b1;
    @(negedge clk);
    chk("rr_req", mem_req, 0);
    chk("rr_busy", busy, 0);
    chk("rr_rdata", ramdata_out, 0);
    chk("rr_err", timeout_err, 0);
    chk("rr_addr", mem_addr, 0);
    chk("rr_we", mem_we, 0);
    chk("rr_ben", mem_ben, 0);
    chk("rr_wdata", mem_wdata, 0);
    reset = 1'b0;
    mute = 0;
    c_valid = 0;
    exp_rd = '0;
    repeat (3) @(negedge clk);
    do_access("rr_next", 22'h155555, 0, 1'b1, 4'hF, 16'h0, 16'h0, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
